instr_mem_loader: RTL and testbench

Byte-serial loader that fills the 64-word instruction memory at run time, the write-side counterpart of the instruction fetch path. Accepts a byte stream over a valid/ready handshake and packs each group of four bytes big-endian: the first byte is memory byte lane 0 and lands in the instruction's bits [31:24]. Issues one word write per packed instruction at sequential word addresses starting from 0. Sits between a host/debug byte source and the instruction memory's write port; the fetch side is untouched.

---
 rtl/instr_mem_loader.sv | 157 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Byte-serial loader for the instruction memory write port.
//            Collects a valid/ready byte stream, packs every four bytes
//            big-endian (first byte -> bits [31:24]) and issues one word
//            write per instruction at sequential word addresses from 0.
//            A finish request flushes a partial word (low lanes zero-padded)
//            and ends the load; the load also ends when DEPTH words exist.
// Ports    : clk          - clock, all state on rising edge
//            reset        - asynchronous active-high reset
//            start        - begins a load at word 0 (IDLE / DONE only)
//            byteIn       - stream byte
//            byteValid    - byteIn is valid
//            byteReady    - loader accepts a byte this cycle
//            finish       - end of stream, flushes any partial word
//            writeEnable  - one-cycle write strobe to instruction memory
//            writeAddr    - byte address of the written word
//            writeData    - packed instruction word
//            wordCount    - words written in the current/last load
//            busy         - loader in COLLECT or WRITE
//            done         - load complete, held until start/reset
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               byteIn,
  input  logic                     byteValid,
  output logic                     byteReady,
  input  logic                     finish,
  output logic                     writeEnable,
  output logic [31:0]              writeAddr,
  output logic [31:0]              writeData,
  output logic [$clog2(DEPTH):0]   wordCount,
  output logic                     busy,
  output logic                     done
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_last_word = c_cw'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_asm;
  logic              r_finish_pend;
  logic [c_cw-1:0]   r_word_count;
  logic [31:0]       r_write_addr;
  logic [31:0]       r_write_data;

  logic              w_xfer;
  logic              w_have_bytes;
  logic [31:0]       w_asm_next;
  logic [31:0]       w_addr;

  // byteReady is decoded from state, so in COLLECT a valid byte is a transfer.
  assign w_xfer       = (r_state == S_COLLECT) && byteValid;
  // A byte arriving with finish counts towards the partial word.
  assign w_have_bytes = w_xfer || (r_byte_idx != 2'd0);
  // The word index never reaches DEPTH while collecting, so the low bits suffice.
  assign w_addr       = {{(32-c_aw-2){1'b0}}, r_word_count[c_aw-1:0], 2'b00};

  // Merge the incoming byte into its lane; lane 0 is the most significant.
  always_comb begin
    w_asm_next = r_asm;
    if (w_xfer) begin
      case (r_byte_idx)
        2'd0:    w_asm_next[31:24] = byteIn;
        2'd1:    w_asm_next[23:16] = byteIn;
        2'd2:    w_asm_next[15:8]  = byteIn;
        default: w_asm_next[7:0]   = byteIn;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_byte_idx    <= 2'd0;
      r_asm         <= 32'd0;
      r_finish_pend <= 1'b0;
      r_word_count  <= '0;
      r_write_addr  <= 32'd0;
      r_write_data  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state       <= S_COLLECT;
            r_byte_idx    <= 2'd0;
            r_asm         <= 32'd0;
            r_finish_pend <= 1'b0;
            r_word_count  <= '0;
          end
        end

        S_COLLECT: begin
          if (w_xfer) begin
            r_asm      <= w_asm_next;
            r_byte_idx <= r_byte_idx + 2'd1;
          end
          if (w_xfer && (r_byte_idx == 2'd3)) begin
            r_state       <= S_WRITE;
            r_finish_pend <= finish;
            r_write_addr  <= w_addr;
            r_write_data  <= w_asm_next;
          end else if (finish) begin
            if (w_have_bytes) begin
              // Partial word: unfilled low lanes are still zero from the clear.
              r_state       <= S_WRITE;
              r_finish_pend <= 1'b1;
              r_write_addr  <= w_addr;
              r_write_data  <= w_asm_next;
            end else begin
              r_state <= S_DONE;
            end
          end
        end

        S_WRITE: begin
          r_word_count  <= r_word_count + c_cw'(1);
          r_byte_idx    <= 2'd0;
          r_asm         <= 32'd0;
          r_finish_pend <= 1'b0;
          if (r_finish_pend || (r_word_count == c_last_word)) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_COLLECT;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign byteReady   = (r_state == S_COLLECT);
  assign writeEnable = (r_state == S_WRITE);
  assign busy        = (r_state == S_COLLECT) || (r_state == S_WRITE);
  assign done        = (r_state == S_DONE);
  assign writeAddr   = r_write_addr;
  assign writeData   = r_write_data;
  assign wordCount   = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loader
// Purpose  : Self-checking bench for instr_mem_loader. Loads are described
//            as byte lists; the expected memory writes are derived from the
//            byte list by packing groups of four big-endian, zero-padding
//            the tail and capping at DEPTH words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

  localparam int DEPTH = 64;

  logic                   clk;
  logic                   reset;
  logic                   start;
  logic [7:0]             byteIn;
  logic                   byteValid;
  logic                   byteReady;
  logic                   finish;
  logic                   writeEnable;
  logic [31:0]            writeAddr;
  logic [31:0]            writeData;
  logic [$clog2(DEPTH):0] wordCount;
  logic                   busy;
  logic                   done;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];

  instr_mem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .byteIn(byteIn),
    .byteValid(byteValid), .byteReady(byteReady), .finish(finish),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .wordCount(wordCount), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (writeEnable) begin
      cap_addr.push_back(writeAddr);
      cap_data.push_back(writeData);
    end
  end

  typedef struct {
    int          nbytes;
    logic [7:0]  base;    // bytes are base, base+1, ...
    int          gaps;    // 0 back-to-back, 1 alternate, 2 random
    int          fmode;   // 1 finish alone, 2 finish with last byte
    int          exp_wc;
    logic [31:0] exp_w0;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_caps();
    cap_addr.delete();
    cap_data.delete();
  endtask

  // fmode: 0 no finish, 1 finish pulse after the bytes, 2 finish with last byte
  task automatic load(input logic [7:0] bq[$], input int gaps, input int fmode,
                      input bit wait_done);
    bit tog;
    bit acc;
    int guard;
    tog = 1'b0;
    for (int i = 0; i < bq.size(); i++) begin
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 64) begin
        byteIn = bq[i];
        case (gaps)
          0:       byteValid = 1'b1;
          1:       begin byteValid = tog; tog = !tog; end
          default: byteValid = 1'($urandom_range(0, 1));
        endcase
        acc    = byteValid && byteReady;
        finish = (fmode == 2) && (i == bq.size() - 1) && acc;
        tick();
        guard++;
      end
      if (!acc) begin
        chk("byte accept timeout", 32'd0, 32'd1);
        break;
      end
    end
    byteValid = 1'b0;
    finish    = 1'b0;
    if (fmode == 1 || (fmode == 2 && bq.size() == 0)) begin
      guard = 0;
      while (!byteReady && guard < 20) begin
        tick();
        guard++;
      end
      finish = 1'b1;
      tick();
      finish = 1'b0;
    end
    if (wait_done) begin
      guard = 0;
      while (!done && guard < 20) begin
        tick();
        guard++;
      end
    end
  endtask

  // Reference: pack the byte list four at a time, big-endian, zero-padded.
  task automatic check_load(input string tag, input logic [7:0] bq[$]);
    int nw;
    logic [31:0] w;
    nw = (bq.size() + 3) / 4;
    if (nw > DEPTH) nw = DEPTH;
    chk({tag, " writes"}, cap_data.size(), nw);
    for (int i = 0; i < nw; i++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++)
        if (4 * i + k < bq.size()) w[31 - 8 * k -: 8] = bq[4 * i + k];
      if (i < cap_data.size()) begin
        chk($sformatf("%s addr%0d", tag, i), cap_addr[i], 32'(4 * i));
        chk($sformatf("%s data%0d", tag, i), cap_data[i], w);
      end
    end
    chk({tag, " wordCount"}, 32'(wordCount), nw);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    bit         seen_ready;
    logic [7:0] spec_bytes[4];

    vecs[0] = '{4, 8'h10, 0, 1, 1, 32'h10111213};
    vecs[1] = '{2, 8'hAA, 0, 1, 1, 32'hAAAB0000};
    vecs[2] = '{3, 8'hAA, 0, 2, 1, 32'hAAABAC00};
    vecs[3] = '{0, 8'h00, 0, 1, 0, 32'h00000000};
    vecs[4] = '{8, 8'h00, 1, 1, 2, 32'h00010203};
    vecs[5] = '{5, 8'hF0, 0, 2, 2, 32'hF0F1F2F3};
    vecs[6] = '{4, 8'h80, 0, 2, 1, 32'h80818283};
    vecs[7] = '{1, 8'h7E, 2, 2, 1, 32'h7E000000};

    reset = 1'b1; start = 1'b0; byteIn = 8'd0; byteValid = 1'b0; finish = 1'b0;
    tick(); tick();
    chk("reset byteReady", 32'(byteReady), 32'd0);
    chk("reset writeEnable", 32'(writeEnable), 32'd0);
    chk("reset busy/done", {30'd0, busy, done}, 32'd0);
    chk("reset wordCount", 32'(wordCount), 32'd0);
    chk("reset addr|data", writeAddr | writeData, 32'd0);
    reset = 1'b0;
    tick();

    // Back-to-back word, cycle by cycle.
    clear_caps();
    do_start();
    chk("start byteReady", 32'(byteReady), 32'd1);
    chk("start busy", 32'(busy), 32'd1);
    spec_bytes = '{8'h8C, 8'h01, 8'h00, 8'h04};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b ready%0d", i), 32'(byteReady), 32'd1);
      byteIn = spec_bytes[i];
      byteValid = 1'b1;
      tick();
    end
    chk("b2b writeEnable", 32'(writeEnable), 32'd1);
    chk("b2b writeAddr", writeAddr, 32'h0);
    chk("b2b writeData", writeData, 32'h8C010004);
    chk("b2b ready low", 32'(byteReady), 32'd0);
    byteValid = 1'b0;
    tick();
    chk("b2b we end", 32'(writeEnable), 32'd0);
    chk("b2b ready back", 32'(byteReady), 32'd1);
    chk("b2b wordCount", 32'(wordCount), 32'd1);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("b2b done", 32'(done), 32'd1);
    chk("b2b writes", cap_data.size(), 32'd1);

    // Table-driven loads, each started from DONE.
    foreach (vecs[v]) begin
      do_start();
      chk($sformatf("vec%0d done cleared", v), 32'(done), 32'd0);
      chk($sformatf("vec%0d wc cleared", v), 32'(wordCount), 32'd0);
      clear_caps();
      q.delete();
      for (int i = 0; i < vecs[v].nbytes; i++) q.push_back(vecs[v].base + 8'(i));
      load(q, vecs[v].gaps, vecs[v].fmode, 1'b1);
      check_load($sformatf("vec%0d", v), q);
      chk($sformatf("vec%0d exp wc", v), 32'(wordCount), vecs[v].exp_wc);
      if (vecs[v].exp_wc > 0 && cap_data.size() > 0)
        chk($sformatf("vec%0d exp w0", v), cap_data[0], vecs[v].exp_w0);
    end

    // Full memory: 256 bytes, then an extra byte must never be taken.
    do_start();
    clear_caps();
    q.delete();
    for (int i = 0; i < 4 * DEPTH; i++) q.push_back(8'(i / 4));
    load(q, 0, 0, 1'b0);
    tick();
    chk("full done", 32'(done), 32'd1);
    chk("full ready", 32'(byteReady), 32'd0);
    seen_ready = 1'b0;
    byteIn = 8'hFF;
    byteValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (byteReady) seen_ready = 1'b1;
    end
    byteValid = 1'b0;
    chk("full extra byte", 32'(seen_ready), 32'd0);
    check_load("full", q);

    // Reset in the middle of word 3.
    do_start();
    clear_caps();
    q.delete();
    for (int i = 0; i < 14; i++) q.push_back(8'h40 + 8'(i));
    load(q, 0, 0, 1'b0);
    chk("pre-reset wordCount", 32'(wordCount), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("async reset flags", {28'd0, byteReady, writeEnable, busy, done}, 32'd0);
    chk("async reset wordCount", 32'(wordCount), 32'd0);
    chk("async reset addr|data", writeAddr | writeData, 32'd0);
    tick();
    chk("reset writes", cap_data.size(), 32'd3);
    reset = 1'b0;
    tick();
    do_start();
    clear_caps();
    q.delete();
    q.push_back(8'h12); q.push_back(8'h34); q.push_back(8'h56); q.push_back(8'h78);
    load(q, 0, 1, 1'b1);
    check_load("after reset", q);

    // start pulses in COLLECT and WRITE are ignored.
    do_start();
    clear_caps();
    q.delete();
    q.push_back(8'h11); q.push_back(8'h22);
    load(q, 0, 0, 1'b0);
    do_start();
    q.delete();
    q.push_back(8'h33); q.push_back(8'h44);
    load(q, 0, 0, 1'b0);
    chk("write before start", 32'(writeEnable), 32'd1);
    do_start();
    q.delete();
    q.push_back(8'h55); q.push_back(8'h66); q.push_back(8'h77); q.push_back(8'h88);
    load(q, 0, 1, 1'b1);
    q.delete();
    for (int i = 1; i <= 8; i++) q.push_back(8'(8'h11 * i));
    check_load("start ignored", q);

    // Randomized loads against the packing reference.
    for (int r = 0; r < 12; r++) begin
      do_start();
      clear_caps();
      q.delete();
      for (int i = 0; i < int'($urandom_range(0, 20)); i++) q.push_back(8'($urandom));
      load(q, 2, int'($urandom_range(1, 2)), 1'b1);
      check_load($sformatf("rand%0d", r), q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
